// File: rtl/pspin_hostmem_ar_split.sv
// pspin_hostmem_ar_split: splits upstream AXI4 read bursts at a fixed address boundary and merges the R beats back into one burst.
module pspin_hostmem_ar_split #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 512,
  parameter int ID_WIDTH     = 8,
  parameter int ARUSER_WIDTH = 1,
  parameter int RUSER_WIDTH  = 1,
  parameter int BOUNDARY     = 4096
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    err_len_mismatch
);
  localparam int BW = $clog2(BOUNDARY);
  localparam int CW = (BW + 1 > 9) ? BW + 1 : 9;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;
  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cur_addr, aligned;
  logic [8:0]              rem_beats, sub_cnt, sub_len, sub_beats;
  logic [ID_WIDTH-1:0]     id;
  logic [2:0]              size;
  logic [1:0]              burst;
  logic [3:0]              cache;
  logic [2:0]              prot;
  logic [ARUSER_WIDTH-1:0] user;
  logic [BW:0]             to_bnd;
  logic                    in_r, incr, r_hs;
  assign incr      = burst == 2'b01;
  assign aligned   = cur_addr & ~((ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1));
  assign to_bnd    = ((BW+1)'(BOUNDARY) - {1'b0, aligned[BW-1:0]}) >> size;
  assign sub_beats = (incr && CW'(to_bnd) < CW'(rem_beats)) ? 9'(to_bnd) : rem_beats;
  assign in_r      = state == WAIT_R;
  assign r_hs      = in_r && m_axi_rvalid && s_axi_rready;
  assign m_axi_arid    = id;
  assign m_axi_araddr  = cur_addr;
  assign m_axi_arlen   = 8'(sub_beats - 9'd1);
  assign m_axi_arsize  = size;
  assign m_axi_arburst = burst;
  assign m_axi_arcache = cache;
  assign m_axi_arprot  = prot;
  assign m_axi_aruser  = user;
  assign s_axi_rvalid  = in_r && m_axi_rvalid;
  assign m_axi_rready  = in_r && s_axi_rready;
  assign s_axi_rid     = id;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_ruser   = m_axi_ruser;
  // rlast is only passed upstream on the sub-burst that drains the remaining beats
  assign s_axi_rlast   = m_axi_rlast && rem_beats == sub_len;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      s_axi_arready    <= 1'b0;
      m_axi_arvalid    <= 1'b0;
      err_len_mismatch <= 1'b0;
      cur_addr         <= '0;
      rem_beats        <= '0;
      sub_cnt          <= '0;
      sub_len          <= '0;
      id               <= '0;
      size             <= '0;
      burst            <= '0;
      cache            <= '0;
      prot             <= '0;
      user             <= '0;
    end else begin
      err_len_mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            cur_addr      <= s_axi_araddr;
            rem_beats     <= 9'(s_axi_arlen) + 9'd1;
            id            <= s_axi_arid;
            size          <= s_axi_arsize;
            burst         <= s_axi_arburst;
            cache         <= s_axi_arcache;
            prot          <= s_axi_arprot;
            user          <= s_axi_aruser;
            s_axi_arready <= 1'b0;
            m_axi_arvalid <= 1'b1;
            state         <= ISSUE;
          end else s_axi_arready <= 1'b1;
        end
        ISSUE: begin
          if (m_axi_arready) begin
            sub_cnt       <= sub_beats;
            sub_len       <= sub_beats;
            m_axi_arvalid <= 1'b0;
            state         <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (r_hs) begin
            sub_cnt <= sub_cnt - 9'd1;
            if (m_axi_rlast) begin
              err_len_mismatch <= sub_cnt != 9'd1;
              rem_beats        <= rem_beats - sub_len;
              if (incr) cur_addr <= aligned + (ADDR_WIDTH'(sub_len) << size);
              if (rem_beats == sub_len) begin
                state         <= IDLE;
                s_axi_arready <= 1'b1;
              end else begin
                state         <= ISSUE;
                m_axi_arvalid <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pspin_hostmem_ar_split.sv
// tb_pspin_hostmem_ar_split: directed table, random bursts against a byte-address split model, and error/reset sequences.
module tb_pspin_hostmem_ar_split;
  localparam int DW = 512;
  localparam longint BND = 4096;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]    s_axi_arid = '0, s_axi_rid, m_axi_arid, m_axi_rid = '0;
  logic [63:0]   s_axi_araddr = '0, m_axi_araddr;
  logic [7:0]    s_axi_arlen = '0, m_axi_arlen;
  logic [2:0]    s_axi_arsize = '0, m_axi_arsize, s_axi_arprot = '0, m_axi_arprot;
  logic [1:0]    s_axi_arburst = '0, m_axi_arburst, s_axi_rresp, m_axi_rresp = '0;
  logic [3:0]    s_axi_arcache = '0, m_axi_arcache;
  logic [0:0]    s_axi_aruser = '0, m_axi_aruser, s_axi_ruser, m_axi_ruser = '0;
  logic [DW-1:0] s_axi_rdata, m_axi_rdata = '0;
  logic s_axi_arvalid = 1'b0, s_axi_arready, s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
  logic m_axi_arvalid, m_axi_arready = 1'b0, m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
  logic err_len_mismatch;

  pspin_hostmem_ar_split dut (
    .clk(clk), .rstn(rstn),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache),
    .s_axi_arprot(s_axi_arprot), .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_len_mismatch(err_len_mismatch)
  );

  typedef struct {logic [63:0] addr; int len; int size; logic [1:0] burst;} ar_t;
  typedef struct {logic [63:0] data; logic [1:0] resp; logic last; logic [7:0] id;} rb_t;
  typedef struct {logic [63:0] addr; int len; int size; logic [1:0] burst; int n_ar; logic [63:0] last_addr; int first_len;} vec_t;
  int checks = 0, errors = 0;
  ar_t dn_q[$], dn_log[$];
  rb_t up_log[$];
  int dn_beat = 0, err_cnt = 0;
  bit up_ar_pend = 0, stall_en = 0, short_en = 0, err_en = 0;
  bit prev_dn_last = 0, prev_up_last = 0, prev_up_ar = 0;
  logic [63:0] err_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address of beat i of a burst, from AXI4 burst rules
  function automatic logic [63:0] beat_addr(input ar_t a, input int i);
    logic [63:0] b;
    b = 64'(1) << a.size;
    if (a.burst == 2'b00 || i == 0) return a.addr;
    return a.addr - a.addr % b + 64'(i) * b;
  endfunction

  // One clock: drive at the falling edge, settle, then record the handshakes the next rising edge will take
  task automatic step();
    logic [63:0] ba;
    @(negedge clk);
    s_axi_arvalid = up_ar_pend;
    s_axi_rready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    m_axi_arready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (dn_q.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
      ba = beat_addr(dn_q[0], dn_beat);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = DW'(ba);
      m_axi_rid    = 8'($urandom);
      m_axi_ruser  = 1'($urandom);
      m_axi_rresp  = (err_en && ba == err_addr) ? 2'b10 : 2'b00;
      m_axi_rlast  = dn_beat == (short_en ? 1 : dn_q[0].len);
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
    end
    #1;
    if (err_len_mismatch) err_cnt++;
    if (prev_up_ar) begin
      check("arready_drop", 64'(s_axi_arready), 64'(0));
      check("arvalid_rise", 64'(m_axi_arvalid), 64'(1));
    end
    if (prev_dn_last) begin
      if (prev_up_last) check("arready_after_final", 64'(s_axi_arready), 64'(1));
      else check("arvalid_after_sub", 64'(m_axi_arvalid), 64'(1));
    end
    prev_up_ar = 0; prev_dn_last = 0; prev_up_last = 0;
    if (m_axi_rvalid) begin
      check("rready_mirror", 64'(m_axi_rready), 64'(s_axi_rready));
      check("rvalid_pass", 64'(s_axi_rvalid), 64'(1));
    end
    if (m_axi_rvalid && m_axi_rready) begin
      if (m_axi_rlast) begin
        void'(dn_q.pop_front());
        dn_beat = 0;
        prev_dn_last = 1;
      end else dn_beat++;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_t a;
      a = '{m_axi_araddr, int'(m_axi_arlen), int'(m_axi_arsize), m_axi_arburst};
      dn_q.push_back(a);
      dn_log.push_back(a);
    end
    if (s_axi_rvalid && s_axi_rready) begin
      up_log.push_back('{s_axi_rdata[63:0], s_axi_rresp, s_axi_rlast, s_axi_rid});
      if (s_axi_rlast) prev_up_last = 1;
    end
    if (s_axi_arvalid && s_axi_arready) begin
      up_ar_pend = 0;
      prev_up_ar = 1;
    end
  endtask

  task automatic start_burst(input logic [63:0] addr, input int len, input int size, input logic [1:0] bu);
    dn_log.delete(); up_log.delete(); err_cnt = 0;
    s_axi_arid = 8'($urandom); s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = bu; s_axi_arcache = 4'($urandom);
    s_axi_arprot = 3'($urandom); s_axi_aruser = 1'($urandom);
    up_ar_pend = 1;
  endtask

  task automatic wait_last();
    int n;
    n = 0;
    while (!(up_log.size() > 0 && up_log[$].last) && n < 5000) begin step(); n++; end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL timeout: no upstream rlast after %0d cycles", n);
    end
  endtask

  task automatic run_burst(input logic [63:0] addr, input int len, input int size, input logic [1:0] bu);
    ar_t exp_q[$];
    logic [63:0] b, a, al, nb, ba;
    longint rem, fit, n;
    start_burst(addr, len, size, bu);
    wait_last();
    step();
    b = 64'(1) << size;
    a = addr;
    rem = len + 1;
    if (bu != 2'b01) exp_q.push_back('{addr, len, size, bu});
    else while (rem > 0) begin
      al = a - a % b;
      nb = (a / 64'(BND) + 64'(1)) * 64'(BND);
      fit = longint'((nb - al) / b);
      n = rem < fit ? rem : fit;
      exp_q.push_back('{a, int'(n - 1), size, bu});
      rem -= n;
      a = al + 64'(n) * b;
    end
    check("n_ar", 64'(dn_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < dn_log.size(); i++) begin
      check("ar_addr", dn_log[i].addr, exp_q[i].addr);
      check("ar_len", 64'(dn_log[i].len), 64'(exp_q[i].len));
      check("ar_size_burst", {58'(dn_log[i].size), 4'(0), dn_log[i].burst}, {58'(size), 4'(0), bu});
    end
    check("n_beats", 64'(up_log.size()), 64'(len + 1));
    for (int k = 0; k <= len && k < up_log.size(); k++) begin
      ba = beat_addr('{addr, len, size, bu}, k);
      check("r_data", up_log[k].data, ba);
      check("r_resp", 64'(up_log[k].resp), (err_en && ba == err_addr) ? 64'(2) : 64'(0));
      check("r_last", 64'(up_log[k].last), 64'(k == len));
      check("r_id", 64'(up_log[k].id), 64'(s_axi_arid));
    end
    check("no_err_pulse", 64'(err_cnt), 64'(0));
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{64'h1000, 3,   6, 2'b01, 1, 64'h1000, 3};
    tbl[1] = '{64'h0FC0, 3,   6, 2'b01, 2, 64'h1000, 0};
    tbl[2] = '{64'h0000, 255, 6, 2'b01, 4, 64'h3000, 63};
    tbl[3] = '{64'h0FC0, 3,   6, 2'b00, 1, 64'h0FC0, 3};
    tbl[4] = '{64'h0FFE, 3,   2, 2'b01, 2, 64'h1000, 0};
    tbl[5] = '{64'h0F00, 3,   6, 2'b01, 1, 64'h0F00, 3};
    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", 64'(s_axi_arready), 64'(0));
    check("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    check("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
    check("rst_err", 64'(err_len_mismatch), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1 check("arready_before_edge", 64'(s_axi_arready), 64'(0));
    @(posedge clk);
    #1 check("arready_after_release", 64'(s_axi_arready), 64'(1));

    foreach (tbl[i]) begin
      run_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst);
      check("tbl_n_ar", 64'(dn_log.size()), 64'(tbl[i].n_ar));
      if (dn_log.size() > 0) begin
        check("tbl_first_len", 64'(dn_log[0].len), 64'(tbl[i].first_len));
        check("tbl_last_addr", dn_log[$].addr, tbl[i].last_addr);
      end
    end

    stall_en = 1; err_en = 1; err_addr = 64'h1000;
    run_burst(64'h0FC0, 3, 6, 2'b01);
    if (up_log.size() > 1) check("slverr_beat2", 64'(up_log[1].resp), 64'(2));
    stall_en = 0; err_en = 0;

    for (int t = 0; t < 25; t++) begin
      logic [63:0] a;
      int l, s;
      logic [1:0] bu;
      s  = $urandom_range(0, 6);
      l  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      a  = 64'($urandom_range(1, 4)) * 64'(BND) - 64'($urandom_range(0, 600));
      bu = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      stall_en = 1'($urandom_range(0, 1));
      err_en   = 1'($urandom_range(0, 1));
      err_addr = beat_addr('{a, l, s, bu}, $urandom_range(0, l));
      run_burst(a, l, s, bu);
    end
    stall_en = 0; err_en = 0;

    short_en = 1;
    start_burst(64'h1000, 3, 6, 2'b01);
    wait_last();
    step();
    check("err_pulse", 64'(err_len_mismatch), 64'(1));
    step();
    check("err_one_cycle", 64'(err_len_mismatch), 64'(0));
    check("short_beats", 64'(up_log.size()), 64'(2));
    short_en = 0;

    start_burst(64'h0, 255, 6, 2'b01);
    for (int n = 0; n < 500 && up_log.size() < 5; n++) step();
    check("midburst_progress", 64'(up_log.size() >= 5), 64'(1));
    rstn = 1'b0;
    #1;
    check("mid_rst_arready", 64'(s_axi_arready), 64'(0));
    check("mid_rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'(0));
    check("mid_rst_rready", 64'(m_axi_rready), 64'(0));
    check("mid_rst_err", 64'(err_len_mismatch), 64'(0));
    dn_q.delete(); dn_beat = 0; up_ar_pend = 0;
    s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    prev_up_ar = 0; prev_dn_last = 0; prev_up_last = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1 check("mid_rel_arready_low", 64'(s_axi_arready), 64'(0));
    @(posedge clk);
    #1 check("mid_rel_arready", 64'(s_axi_arready), 64'(1));
    run_burst(64'h0FC0, 3, 6, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
